// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the MEM stage: funct3 access codes, FSM encoding and
// the size-driven helpers used for alignment checks and store lane steering.
package riscv_mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } mem_state_t;

   // Size code is funct3[1:0]: 00 byte, 01 half, anything else is a word access.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
      case (size)
         2'b00:   return 1'b0;
         2'b01:   return lo[0];
         default: return lo != 2'b00;
      endcase
   endfunction

   function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lo);
      case (size)
         2'b00:   return 4'b0001 << lo;
         2'b01:   return 4'b0011 << {lo[1], 1'b0};
         default: return 4'hF;
      endcase
   endfunction

   function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] d);
      case (size)
         2'b00:   return {4{d[7:0]}};
         2'b01:   return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it
// according to funct3; word and undefined encodings return the word unchanged.
module load_align
   import riscv_mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
   always_comb begin
      lane_b = rdata[{addr_lo, 3'b000} +: 8];
      lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         F3_B:    data = {{24{lane_b[7]}}, lane_b};
         F3_H:    data = {{16{lane_h[15]}}, lane_h};
         F3_BU:   data = {24'd0, lane_b};
         F3_HU:   data = {16'd0, lane_h};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: passes ALU results straight through, runs loads/stores over a
// req/ready bus with a timeout, and presents the MEM/WB signal set.
module mem_access_stage
   import riscv_mem_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_in,
   input  logic [31:0] alu_result_in,
   input  logic [31:0] store_data_in,
   input  logic [2:0]  funct3_in,
   input  logic [4:0]  rd_in,
   input  logic        reg_write_in,
   input  logic        mem_to_reg_in,
   input  logic        mem_read_in,
   input  logic        mem_write_in,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] mem_data_out,
   output logic [31:0] alu_result_out,
   output logic [4:0]  rd_out,
   output logic        reg_write_out,
   output logic        mem_to_reg_out,
   output logic        stall_out,
   output logic        misaligned_out,
   output logic        bus_err_out
);

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   mem_state_t  state;
   logic [7:0]  wait_cnt;
   logic [31:0] addr_q;
   logic [31:0] mem_data_q;
   logic [4:0]  rd_q;
   logic [2:0]  funct3_q;
   logic        reg_write_q;
   logic        mem_to_reg_q;
   logic        load_q;
   logic        err_q;
   logic [31:0] load_word;

   logic mem_op;
   logic bad_align;
   logic start;

   assign mem_op    = valid_in & (mem_read_in | mem_write_in);
   assign bad_align = mem_op & misaligned(funct3_in[1:0], alu_result_in[1:0]);
   assign start     = (state == ST_IDLE) & mem_op & ~bad_align;
   assign dmem_addr = {addr_q[31:2], 2'b00};

   load_align u_load_align (
      .rdata   (dmem_rdata),
      .addr_lo (addr_q[1:0]),
      .funct3  (funct3_q),
      .data    (load_word)
   );

   // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= ST_IDLE;
         wait_cnt     <= '0;
         addr_q       <= '0;
         mem_data_q   <= '0;
         rd_q         <= '0;
         funct3_q     <= '0;
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         load_q       <= 1'b0;
         err_q        <= 1'b0;
         dmem_req     <= 1'b0;
         dmem_we      <= 1'b0;
         dmem_wdata   <= '0;
         dmem_be      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state        <= ST_BUSY;
                  dmem_req     <= 1'b1;
                  wait_cnt     <= '0;
                  err_q        <= 1'b0;
                  addr_q       <= alu_result_in;
                  dmem_we      <= mem_write_in;
                  dmem_wdata   <= store_wdata(funct3_in[1:0], store_data_in);
                  dmem_be      <= store_be(funct3_in[1:0], alu_result_in[1:0]);
                  rd_q         <= rd_in;
                  funct3_q     <= funct3_in;
                  reg_write_q  <= reg_write_in;
                  mem_to_reg_q <= mem_to_reg_in;
                  load_q       <= mem_read_in;
               end
            end
            ST_BUSY: begin
               wait_cnt <= wait_cnt + 8'd1;
               if (dmem_ready) begin
                  state      <= ST_DONE;
                  dmem_req   <= 1'b0;
                  mem_data_q <= load_q ? load_word : 32'd0;
               end else if (wait_cnt == TIMEOUT_LAST) begin
                  state      <= ST_DONE;
                  dmem_req   <= 1'b0;
                  err_q      <= 1'b1;
                  mem_data_q <= '0;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // While an access is in flight the MEM/WB view comes from the captured copy.
   always_comb begin
      alu_result_out = alu_result_in;
      rd_out         = rd_in;
      mem_to_reg_out = mem_to_reg_in;
      reg_write_out  = reg_write_in & valid_in;
      mem_data_out   = '0;
      stall_out      = 1'b0;
      misaligned_out = 1'b0;
      bus_err_out    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bad_align) begin
               misaligned_out = 1'b1;
               reg_write_out  = 1'b0;
            end else if (mem_op) begin
               stall_out     = 1'b1;
               reg_write_out = 1'b0;
            end
         end
         ST_BUSY: begin
            alu_result_out = addr_q;
            rd_out         = rd_q;
            mem_to_reg_out = mem_to_reg_q;
            reg_write_out  = 1'b0;
            stall_out      = 1'b1;
         end
         ST_DONE: begin
            alu_result_out = addr_q;
            rd_out         = rd_q;
            mem_to_reg_out = mem_to_reg_q;
            reg_write_out  = reg_write_q & ~err_q;
            mem_data_out   = mem_data_q;
            bus_err_out    = err_q;
         end
         default: ;
      endcase
   end

endmodule
